// File: rtl/onehot_sel_pipe.sv
// Registered one-hot N:1 result select with valid/ready handshake, a skid entry,
// per-beat select-error sideband and a saturating error counter.
module onehot_sel_pipe #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 5,
  parameter int PRIO  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NSRC*WIDTH-1:0] src,
  input  logic [NSRC-1:0]       sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  sel_err,
  input  logic                  clr_err,
  output logic [15:0]           err_cnt
);

  localparam logic [NSRC-1:0] SEL_ONE = NSRC'(1);

  logic [WIDTH-1:0] sel_data;
  logic             sel_bad;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             accept;
  logic             slot_free;

  // PRIO=1 scans downward so the lowest selected index is the last to write.
  always_comb begin
    sel_data = '0;
    if (PRIO == 0) begin
      for (int k = 0; k < NSRC; k++) begin
        if (sel[k]) sel_data = sel_data | src[k*WIDTH +: WIDTH];
      end
    end else begin
      for (int k = NSRC - 1; k >= 0; k--) begin
        if (sel[k]) sel_data = src[k*WIDTH +: WIDTH];
      end
    end
    sel_bad = (sel == '0) || ((sel & (sel - SEL_ONE)) != '0);
  end

  // in_ready comes straight off the skid flop, so out_ready never reaches it.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign slot_free = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      result     <= '0;
      sel_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
    end else if (slot_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        result     <= skid_data;
        sel_err    <= skid_err;
        skid_valid <= accept;
        if (accept) begin
          skid_data <= sel_data;
          skid_err  <= sel_bad;
        end
      end else if (accept) begin
        out_valid <= 1'b1;
        result    <= sel_data;
        sel_err   <= sel_bad;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= sel_data;
      skid_err   <= sel_bad;
    end
  end

  // Clear wins over a same-cycle bad beat; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (accept && sel_bad && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule
